// File: rtl/synthesizer_input_stretcher.sv
// Re-spaces back-to-back channel frames into one output sample every OUTPUT_SPACING cycles.
// Define SYNTH_STRETCHER_STATS_EN to add the Stats_frames_out / Stats_underflows ports.
module synthesizer_input_stretcher #(
    parameter int NUM_CHANNELS   = 16,
    parameter int DATA_WIDTH     = 22,
    parameter int FIFO_DEPTH     = 64,
    parameter int OUTPUT_SPACING = 4
) (
    input  logic                              Clk,
    input  logic                              Rst_n,
    input  logic                              Input_valid,
    input  logic [$clog2(NUM_CHANNELS)-1:0]   Input_index,
    input  logic                              Input_last,
    input  logic [1:0][DATA_WIDTH-1:0]        Input_data,
    input  logic [NUM_CHANNELS-1:0]           Channel_mask,
    output logic                              Output_valid,
    output logic [$clog2(NUM_CHANNELS)-1:0]   Output_index,
    output logic                              Output_last,
    output logic [1:0][DATA_WIDTH-1:0]        Output_data,
    output logic                              Error_overflow,
    output logic                              Error_underflow,
    output logic                              Error_sequence
`ifdef SYNTH_STRETCHER_STATS_EN
    ,
    output logic [31:0]                       Stats_frames_out,
    output logic [15:0]                       Stats_underflows
`endif
);

    localparam int IDX_W  = $clog2(NUM_CHANNELS);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int FC_W   = $clog2(FIFO_DEPTH / NUM_CHANNELS) + 1;
    localparam int SLOT_W = (OUTPUT_SPACING > 1) ? $clog2(OUTPUT_SPACING) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [SLOT_W-1:0] SLOT_RELOAD = SLOT_W'(OUTPUT_SPACING - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    logic [1:0][DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr, commit_ptr, rd_ptr;
    logic [IDX_W-1:0]  exp_idx, out_idx;
    logic              resync;
    logic [FC_W-1:0]   frame_cnt, frame_cnt_nxt;
    logic [SLOT_W-1:0] slot_cnt;
    state_t            state, state_nxt;

    logic exp_last, idx_ok, take, fifo_full, fifo_empty;
    logic wr_en, overflow, seq_err, last_wr;
    logic slot_due, rd_en, underflow, out_last_now, last_rd;

    // commit_ptr marks the end of the last complete frame; reads never pass it,
    // so a partial frame can always be rewound safely.
    assign exp_last   = (exp_idx == LAST_IDX);
    assign idx_ok     = (Input_index == exp_idx) && (Input_last == exp_last);
    assign take       = Input_valid && idx_ok;
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign fifo_empty = (rd_ptr == commit_ptr);
    assign wr_en      = take && !fifo_full;
    assign overflow   = take && fifo_full;
    assign seq_err    = Input_valid && !idx_ok && !resync;
    assign last_wr    = wr_en && exp_last;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            exp_idx    <= '0;
            resync     <= 1'b0;
        end else if (wr_en) begin
            wr_ptr  <= wr_ptr + PTR_W'(1);
            exp_idx <= exp_last ? '0 : exp_idx + IDX_W'(1);
            resync  <= 1'b0;
            if (exp_last)
                commit_ptr <= wr_ptr + PTR_W'(1);
        end else if (seq_err || overflow) begin
            wr_ptr  <= commit_ptr;
            exp_idx <= '0;
            resync  <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_ptr[ADDR_W-1:0]] <= Input_data;
    end

    always_comb begin
        frame_cnt_nxt = frame_cnt;
        if (last_wr && !last_rd)
            frame_cnt_nxt = frame_cnt + FC_W'(1);
        else if (!last_wr && last_rd)
            frame_cnt_nxt = frame_cnt - FC_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt_nxt;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Using the post-update frame count lets a frame completing this cycle start
    // emission immediately and keeps back-to-back frames on the same slot grid.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_cnt_nxt != '0) state_nxt = EMIT;
            EMIT:    if (slot_due && out_last_now && frame_cnt_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        slot_due     = (state == EMIT) && (slot_cnt == '0);
        out_last_now = (out_idx == LAST_IDX);
        rd_en        = slot_due && !fifo_empty;
        underflow    = slot_due && fifo_empty;
        last_rd      = rd_en && out_last_now;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr   <= '0;
            slot_cnt <= '0;
            out_idx  <= '0;
        end else begin
            if (rd_en)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (state == IDLE) begin
                slot_cnt <= '0;
                out_idx  <= '0;
            end else if (slot_due) begin
                slot_cnt <= SLOT_RELOAD;
                out_idx  <= out_last_now ? '0 : out_idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt - SLOT_W'(1);
            end
        end
    end

    // An underflowed slot still emits its index/last so downstream frame alignment holds.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Output_valid    <= 1'b0;
            Output_index    <= '0;
            Output_last     <= 1'b0;
            Output_data     <= '0;
            Error_overflow  <= 1'b0;
            Error_underflow <= 1'b0;
            Error_sequence  <= 1'b0;
        end else begin
            Output_valid    <= slot_due;
            Output_index    <= slot_due ? out_idx : '0;
            Output_last     <= slot_due && out_last_now;
            Output_data     <= (rd_en && Channel_mask[out_idx]) ? mem[rd_ptr[ADDR_W-1:0]] : '0;
            Error_overflow  <= overflow;
            Error_underflow <= underflow;
            Error_sequence  <= seq_err;
        end
    end

`ifdef SYNTH_STRETCHER_STATS_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Stats_frames_out <= '0;
            Stats_underflows <= '0;
        end else begin
            if (slot_due && out_last_now)
                Stats_frames_out <= Stats_frames_out + 32'd1;
            if (underflow && Stats_underflows != 16'hFFFF)
                Stats_underflows <= Stats_underflows + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_synthesizer_input_stretcher.sv
// Scoreboard bench for synthesizer_input_stretcher: directed frames, overflow, sequence
// errors, channel masking, mid-emission reset and (with SYNTH_STRETCHER_STATS_EN) stats.
module tb_synthesizer_input_stretcher;

    localparam int NC    = 16;
    localparam int DW    = 22;
    localparam int DEPTH = 32;
    localparam int SP    = 4;
    localparam int IW    = 4;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          last;
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [IW-1:0]        in_index;
    logic                 in_last;
    logic [1:0][DW-1:0]   in_data;
    logic [NC-1:0]        mask;
    logic                 out_valid;
    logic [IW-1:0]        out_index;
    logic                 out_last;
    logic [1:0][DW-1:0]   out_data;
    logic                 err_ovf;
    logic                 err_udf;
    logic                 err_seq;
`ifdef SYNTH_STRETCHER_STATS_EN
    logic [31:0]          stats_frames;
    logic [15:0]          stats_udf;
`endif

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   out_count = 0;
    int   ovf_cnt = 0;
    int   seq_cnt = 0;
    int   udf_cnt = 0;
    bit   have_prev = 1'b0;
    bit   prev_last = 1'b0;
    bit   strict_gap = 1'b0;
    int   prev_cyc = 0;
    int   idx0_cyc = 0;
    int   last_drive_cyc = 0;

    synthesizer_input_stretcher #(
        .NUM_CHANNELS   (NC),
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .OUTPUT_SPACING (SP)
    ) dut (
        .Clk             (clk),
        .Rst_n           (rst_n),
        .Input_valid     (in_valid),
        .Input_index     (in_index),
        .Input_last      (in_last),
        .Input_data      (in_data),
        .Channel_mask    (mask),
        .Output_valid    (out_valid),
        .Output_index    (out_index),
        .Output_last     (out_last),
        .Output_data     (out_data),
        .Error_overflow  (err_ovf),
        .Error_underflow (err_udf),
        .Error_sequence  (err_seq)
`ifdef SYNTH_STRETCHER_STATS_EN
        ,
        .Stats_frames_out (stats_frames),
        .Stats_underflows (stats_udf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor samples on the falling edge, well away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 1'b0;
        end else begin
            if (out_valid) begin
                out_count++;
                if (out_index == '0)
                    idx0_cyc = cyc;
                compared++;
                assert (exp_q.size() != 0) else begin
                    mismatched++;
                    $error("[TB] FAIL unexpected_output: observed index %0d expected no output", out_index);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_output("out_index", 64'(out_index), 64'(mon_e.idx));
                    check_output("out_last", 64'(out_last), 64'(mon_e.last));
                    check_output("out_i", 64'(out_data[0]), 64'(mon_e.i));
                    check_output("out_q", 64'(out_data[1]), 64'(mon_e.q));
                end
                if (have_prev && (!prev_last || strict_gap))
                    check_output("spacing", 64'(cyc - prev_cyc), 64'(SP));
                have_prev = 1'b1;
                prev_cyc  = cyc;
                prev_last = out_last;
            end
            if (err_ovf) ovf_cnt++;
            if (err_seq) seq_cnt++;
            if (err_udf) udf_cnt++;
        end
    end

    task automatic send_sample(input int idx, input bit last, input logic [DW-1:0] iv, input logic [DW-1:0] qv);
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        in_index   = IW'(idx);
        in_last    = last;
        in_data[0] = iv;
        in_data[1] = qv;
        last_drive_cyc = cyc;
    endtask

    task automatic idle_cycles(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Drives one full frame; expected outputs go on the scoreboard when the frame is driven.
    task automatic apply_stimulus(input int i_base, input int i_step, input int q_base,
                                  input int q_step, input bit expect_out);
        for (int k = 0; k < NC; k++) begin
            exp_t e;
            logic [DW-1:0] iv;
            logic [DW-1:0] qv;
            iv = DW'(i_base + i_step * k);
            qv = DW'(q_base + q_step * k);
            send_sample(k, (k == NC - 1), iv, qv);
            if (expect_out) begin
                e.idx  = IW'(k);
                e.last = (k == NC - 1);
                e.i    = mask[k] ? iv : '0;
                e.q    = mask[k] ? qv : '0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_outputs(input int target, input int budget, input string tag);
        int n = 0;
        while (out_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, 64'(out_count >= target), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1_last;
        int oc0;
        int oc1;
        int ovf0;
        int seq0;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_index = '0;
        in_last  = 1'b0;
        in_data  = '0;
        mask     = '1;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ctrl", 64'({out_valid, out_last, out_index, err_ovf, err_udf, err_seq}), 64'd0);
        check_output("reset_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single clean frame, I=idx, Q=-idx
        $display("[TB] single frame");
        apply_stimulus(0, 1, 0, -1, 1'b1);
        t1_last = last_drive_cyc;
        idle_cycles(0);
        wait_drain(200, "t1_drain");
        idle_cycles(10);
        check_output("t1_latency", 64'(idx0_cyc - t1_last), 64'd2);
        check_output("t1_count", 64'(out_count), 64'd16);
        check_output("t1_errors", 64'(ovf_cnt + seq_cnt + udf_cnt), 64'd0);

        // Three back-to-back frames into a 32-entry FIFO: the third overflows
        $display("[TB] overflow");
        oc0  = out_count;
        ovf0 = ovf_cnt;
        seq0 = seq_cnt;
        apply_stimulus(1000, 3, -1000, -3, 1'b1);
        apply_stimulus(2000, 5, -7, 11, 1'b1);
        apply_stimulus(3000, 1, 3000, 1, 1'b0);
        idle_cycles(0);
        wait_drain(400, "t2_drain");
        idle_cycles(100);
        check_output("t2_count", 64'(out_count - oc0), 64'd32);
        check_output("t2_overflow", 64'(ovf_cnt - ovf0), 64'd1);
        check_output("t2_sequence", 64'(seq_cnt - seq0), 64'd0);
        apply_stimulus(4000, 2, -4000, -2, 1'b1);
        idle_cycles(0);
        wait_drain(200, "t2_recover_drain");
        idle_cycles(10);
        check_output("t2_recover_count", 64'(out_count - oc0), 64'd48);
        check_output("t2_recover_overflow", 64'(ovf_cnt - ovf0), 64'd1);

        // Broken sequence 0,1,2,5 then stray samples, then a clean frame
        $display("[TB] sequence error");
        oc0  = out_count;
        seq0 = seq_cnt;
        send_sample(0, 1'b0, 22'd1, 22'd1);
        send_sample(1, 1'b0, 22'd2, 22'd2);
        send_sample(2, 1'b0, 22'd3, 22'd3);
        send_sample(5, 1'b0, 22'd4, 22'd4);
        send_sample(6, 1'b0, 22'd5, 22'd5);
        send_sample(7, 1'b0, 22'd6, 22'd6);
        idle_cycles(40);
        check_output("t3_seq_pulse", 64'(seq_cnt - seq0), 64'd1);
        check_output("t3_no_output", 64'(out_count - oc0), 64'd0);
        apply_stimulus(50, 1, -50, -1, 1'b1);
        idle_cycles(0);
        wait_drain(200, "t3_drain");
        idle_cycles(10);
        check_output("t3_count", 64'(out_count - oc0), 64'd16);
        check_output("t3_seq_total", 64'(seq_cnt - seq0), 64'd1);

        // Channel 0 masked off
        $display("[TB] channel mask");
        mask = 16'hFFFE;
        apply_stimulus(100, 0, 200, 0, 1'b1);
        idle_cycles(0);
        wait_drain(200, "t4_drain");
        idle_cycles(10);
        mask = '1;

        // Reset in the middle of emitting a frame
        $display("[TB] reset mid-emission");
        oc0 = out_count;
        apply_stimulus(7, 1, 9, 1, 1'b1);
        idle_cycles(0);
        wait_outputs(oc0 + 3, 100, "t5_started");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("t5_reset_ctrl", 64'({out_valid, out_last, out_index, err_ovf, err_udf, err_seq}), 64'd0);
        check_output("t5_reset_data", 64'(out_data), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        oc1 = out_count;
        repeat (100) @(posedge clk);
        check_output("t5_quiet", 64'(out_count - oc1), 64'd0);
        apply_stimulus(300, 1, -300, -1, 1'b1);
        idle_cycles(0);
        wait_drain(200, "t5_drain");
        idle_cycles(10);

        // Five clean frames after reset, fast enough that emission never pauses
        $display("[TB] five frames");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        oc0  = out_count;
        ovf0 = ovf_cnt;
        seq0 = seq_cnt;
        strict_gap = 1'b1;
        for (int f = 0; f < 5; f++) begin
            apply_stimulus(f * 100, 1, -f * 100, 2, 1'b1);
            idle_cycles(35);
        end
        wait_drain(600, "t6_drain");
        idle_cycles(10);
        strict_gap = 1'b0;
        check_output("t6_count", 64'(out_count - oc0), 64'd80);
        check_output("t6_errors", 64'((ovf_cnt - ovf0) + (seq_cnt - seq0)), 64'd0);
`ifdef SYNTH_STRETCHER_STATS_EN
        check_output("t6_stats_frames", 64'(stats_frames), 64'd5);
        check_output("t6_stats_underflows", 64'(stats_udf), 64'd0);
`endif
        check_output("underflow_total", 64'(udf_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
